control_unit_seq: RTL

- Registered, multi-cycle successor to the combinational ID-stage control decoder.
- Decodes mode/op_code/s_in into EXE/MEM/WB control with one cycle of latency.
- Adds a block-transfer sequencer (LDM/STM-style) that expands one instruction into one memory op per set bit of a parametrised register list, and stalls upstream while busy.
- Sits between the IF/ID register and the ID/EXE register. Honours the pipeline freeze and flush inputs.

---
 rtl/control_unit_seq_if.sv | 37 +++
 rtl/control_unit_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_seq_if.sv
// Decode-stage bundle between the IF/ID register, control_unit_seq and the ID/EXE register.
// master drives the decode inputs, slave (the control unit) drives the control outputs.
interface control_unit_seq_if #(
   parameter int unsigned CMD_WIDTH      = 4,
   parameter int unsigned REG_LIST_WIDTH = 16,
   parameter int unsigned IDX_WIDTH      = 4
);
   logic                      valid_in;
   logic [1:0]                mode;
   logic [3:0]                op_code;
   logic                      s_in;
   logic                      block;
   logic [REG_LIST_WIDTH-1:0] reg_list;
   logic                      freeze;
   logic                      flush;

   logic                      busy;
   logic                      valid_out;
   logic [CMD_WIDTH-1:0]      exe_cmd;
   logic                      mem_r_en;
   logic                      mem_w_en;
   logic                      wb_en;
   logic                      s;
   logic                      b;
   logic [IDX_WIDTH-1:0]      burst_idx;
   logic                      burst_last;

   modport master (
      output valid_in, mode, op_code, s_in, block, reg_list, freeze, flush,
      input  busy, valid_out, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, burst_idx, burst_last
   );

   modport slave (
      input  valid_in, mode, op_code, s_in, block, reg_list, freeze, flush,
      output busy, valid_out, exe_cmd, mem_r_en, mem_w_en, wb_en, s, b, burst_idx, burst_last
   );
endinterface

// File: rtl/control_unit_seq.sv
// Registered ID-stage control decoder with an LDM/STM-style block-transfer sequencer.
// Optional multi-cycle multiply support is enabled by defining CU_MUL_EN.
module control_unit_seq #(
   parameter int unsigned CMD_WIDTH      = 4,
   parameter int unsigned REG_LIST_WIDTH = 16,
   parameter int unsigned IDX_WIDTH      = 4,
   parameter int unsigned MUL_CYCLES     = 3
) (
   input logic                clk,
   input logic                rst,
   control_unit_seq_if.slave  cu
);
   if ((2 ** IDX_WIDTH) < REG_LIST_WIDTH) begin : g_idx_chk
      $error("IDX_WIDTH too small for REG_LIST_WIDTH");
   end
   if (MUL_CYCLES < 1) begin : g_mul_chk
      $error("MUL_CYCLES must be at least 1");
   end

   typedef struct packed {
      logic                 valid;
      logic [CMD_WIDTH-1:0] exe_cmd;
      logic                 mem_r_en;
      logic                 mem_w_en;
      logic                 wb_en;
      logic                 s;
      logic                 b;
      logic [IDX_WIDTH-1:0] burst_idx;
      logic                 burst_last;
   } ctrl_t;

`ifdef CU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_BURST, S_MUL} state_t;
   localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);
`else
   typedef enum logic [1:0] {S_IDLE, S_BURST} state_t;
`endif

   state_t                    state_q, state_d;
   logic [REG_LIST_WIDTH-1:0] pending_q, pending_d;
   ctrl_t                     ctrl_q, ctrl_d;
   logic [REG_LIST_WIDTH-1:0] rem;
`ifdef CU_MUL_EN
   logic [CNT_W-1:0]          mul_cnt_q, mul_cnt_d;
   logic                      mul_s_q, mul_s_d;
`endif

   function automatic logic [IDX_WIDTH-1:0] lowest_idx(input logic [REG_LIST_WIDTH-1:0] v);
      lowest_idx = '0;
      for (int i = REG_LIST_WIDTH - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = IDX_WIDTH'(i);
      end
   endfunction

   // Data-processing table; unknown opcodes decode to an all-zero NOP.
   function automatic ctrl_t decode_dp(input logic [3:0] op, input logic s_bit);
      decode_dp            = '0;
      decode_dp.valid      = 1'b1;
      decode_dp.wb_en      = 1'b1;
      decode_dp.s          = s_bit;
      decode_dp.burst_last = 1'b1;
      case (op)
         4'b1101: decode_dp.exe_cmd = CMD_WIDTH'(4'b0001);
         4'b1111: decode_dp.exe_cmd = CMD_WIDTH'(4'b1001);
         4'b0100: decode_dp.exe_cmd = CMD_WIDTH'(4'b0010);
         4'b0101: decode_dp.exe_cmd = CMD_WIDTH'(4'b0011);
         4'b0010: decode_dp.exe_cmd = CMD_WIDTH'(4'b0100);
         4'b0110: decode_dp.exe_cmd = CMD_WIDTH'(4'b0101);
         4'b0000: decode_dp.exe_cmd = CMD_WIDTH'(4'b0110);
         4'b1100: decode_dp.exe_cmd = CMD_WIDTH'(4'b0111);
         4'b0001: decode_dp.exe_cmd = CMD_WIDTH'(4'b1000);
         4'b1010: begin
            decode_dp.exe_cmd = CMD_WIDTH'(4'b0100);
            decode_dp.wb_en   = 1'b0;
         end
         4'b1000: begin
            decode_dp.exe_cmd = CMD_WIDTH'(4'b0110);
            decode_dp.wb_en   = 1'b0;
         end
         default: decode_dp = '0;
      endcase
   endfunction

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      ctrl_d    = ctrl_q;
      rem       = '0;
`ifdef CU_MUL_EN
      mul_cnt_d = mul_cnt_q;
      mul_s_d   = mul_s_q;
`endif
      if (cu.flush) begin
         state_d   = S_IDLE;
         pending_d = '0;
         ctrl_d    = '0;
      end else if (!cu.freeze) begin
         case (state_q)
            S_IDLE: begin
               ctrl_d = '0;
               if (cu.valid_in) begin
                  case (cu.mode)
                     2'b00: ctrl_d = decode_dp(cu.op_code, cu.s_in);
                     2'b01: begin
                        if (!cu.block || (cu.reg_list != '0)) begin
                           ctrl_d.valid    = 1'b1;
                           ctrl_d.exe_cmd  = CMD_WIDTH'(4'b0010);
                           ctrl_d.mem_r_en = cu.s_in;
                           ctrl_d.mem_w_en = !cu.s_in;
                           ctrl_d.wb_en    = cu.s_in;
                           ctrl_d.burst_last = 1'b1;
                        end
                        if (cu.block && (cu.reg_list != '0)) begin
                           rem               = cu.reg_list & (cu.reg_list - REG_LIST_WIDTH'(1));
                           pending_d         = rem;
                           ctrl_d.burst_idx  = lowest_idx(cu.reg_list);
                           ctrl_d.burst_last = (rem == '0);
                           if (rem != '0) state_d = S_BURST;
                        end
                     end
                     2'b10: begin
                        ctrl_d.valid      = 1'b1;
                        ctrl_d.b          = 1'b1;
                        ctrl_d.burst_last = 1'b1;
                     end
                     default: begin
`ifdef CU_MUL_EN
                        if (cu.op_code == 4'b0000) begin
                           state_d   = S_MUL;
                           mul_cnt_d = CNT_W'(1);
                           mul_s_d   = cu.s_in;
                           if (MUL_CYCLES == 1) begin
                              ctrl_d.valid      = 1'b1;
                              ctrl_d.exe_cmd    = CMD_WIDTH'(4'b1010);
                              ctrl_d.wb_en      = 1'b1;
                              ctrl_d.s          = cu.s_in;
                              ctrl_d.burst_last = 1'b1;
                           end
                        end
`endif
                     end
                  endcase
               end
            end
            S_BURST: begin
               // Memory enables and exe_cmd carry over from the first beat.
               rem               = pending_q & (pending_q - REG_LIST_WIDTH'(1));
               pending_d         = rem;
               ctrl_d.valid      = 1'b1;
               ctrl_d.burst_idx  = lowest_idx(pending_q);
               ctrl_d.burst_last = (rem == '0);
               if (rem == '0) state_d = S_IDLE;
            end
`ifdef CU_MUL_EN
            S_MUL: begin
               ctrl_d = '0;
               if (mul_cnt_q == CNT_W'(MUL_CYCLES)) begin
                  state_d = S_IDLE;
               end else begin
                  mul_cnt_d = mul_cnt_q + CNT_W'(1);
                  if ((mul_cnt_q + CNT_W'(1)) == CNT_W'(MUL_CYCLES)) begin
                     ctrl_d.valid      = 1'b1;
                     ctrl_d.exe_cmd    = CMD_WIDTH'(4'b1010);
                     ctrl_d.wb_en      = 1'b1;
                     ctrl_d.s          = mul_s_q;
                     ctrl_d.burst_last = 1'b1;
                  end
               end
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         ctrl_q    <= '0;
`ifdef CU_MUL_EN
         mul_cnt_q <= '0;
         mul_s_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ctrl_q    <= ctrl_d;
`ifdef CU_MUL_EN
         mul_cnt_q <= mul_cnt_d;
         mul_s_q   <= mul_s_d;
`endif
      end
   end

   assign cu.busy       = (state_q != S_IDLE);
   assign cu.valid_out  = ctrl_q.valid;
   assign cu.exe_cmd    = ctrl_q.exe_cmd;
   assign cu.mem_r_en   = ctrl_q.mem_r_en;
   assign cu.mem_w_en   = ctrl_q.mem_w_en;
   assign cu.wb_en      = ctrl_q.wb_en;
   assign cu.s          = ctrl_q.s;
   assign cu.b          = ctrl_q.b;
   assign cu.burst_idx  = ctrl_q.burst_idx;
   assign cu.burst_last = ctrl_q.burst_last;
endmodule
